// File: rtl/mc6809_bus_timer_if.sv
// CPU-side bus bundle for the MC6809 bus timer: address/data/status from the
// CPU, read data and interrupt requests back to it.
interface mc6809_bus_timer_if;
  logic        CE_E_FALL;
  logic [15:0] ADDR;
  logic [7:0]  D;
  logic        RnW;
  logic        BS;
  logic        BA;
  logic [7:0]  DOut;
  logic        DOE;
  logic        nIRQ;
  logic        nFIRQ;

  modport master (
    output CE_E_FALL, ADDR, D, RnW, BS, BA,
    input  DOut, DOE, nIRQ, nFIRQ
  );

  modport slave (
    input  CE_E_FALL, ADDR, D, RnW, BS, BA,
    output DOut, DOE, nIRQ, nFIRQ
  );
endinterface

// File: rtl/mc6809_bus_timer.sv
// 16-bit down-counting timer on a 4-byte MC6809 register window, ticking once
// per E cycle, with latched COUNT_LO reads and level IRQ/FIRQ requests.
module mc6809_bus_timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF40
) (
  input  logic               CLK_ROOT,
  input  logic               nRESET,
  mc6809_bus_timer_if.slave  bus
);

  logic [3:0]  ctrl_q, ctrl_d;
  logic        flag_q, flag_d;
  logic [15:0] count_q, count_d;
  logic [15:0] reload_q, reload_d;
  logic [7:0]  stg_q, stg_d;
  logic [7:0]  hold_q, hold_d;
  logic        hv_q, hv_d;
  logic        nirq_q, nirq_d;
  logic        nfirq_q, nfirq_d;

  logic        sel_s, wr_s, rd_s, tick_s, expire_s, en_clr_s;
  logic [1:0]  off_s;
  logic [7:0]  rdata_s;

  // Address/status decode; BA=1 or BS=1 are never CPU data cycles for us.
  always_comb begin
    sel_s  = (bus.ADDR[15:2] == BASE_ADDR[15:2]) && !bus.BA && !bus.BS;
    off_s  = bus.ADDR[1:0];
    wr_s   = bus.CE_E_FALL && sel_s && !bus.RnW;
    rd_s   = bus.CE_E_FALL && sel_s && bus.RnW;
    tick_s = bus.CE_E_FALL && ctrl_q[0];
  end

  // Counter, control and status next state.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    expire_s = 1'b0;
    en_clr_s = 1'b0;
    if (wr_s && (off_s == 2'd3)) begin
      count_d  = {stg_q, bus.D};
      reload_d = {stg_q, bus.D};
    end else if (tick_s) begin
      if (count_q != 16'h0000) begin
        count_d = count_q - 16'd1;
      end else begin
        expire_s = 1'b1;
        if (ctrl_q[1]) begin
          count_d = reload_q;
        end else begin
          en_clr_s = 1'b1;
        end
      end
    end else begin
      count_d = count_q;
    end

    // A CTRL write overrides the one-shot EN clear; the tick above used old EN.
    ctrl_d = (wr_s && (off_s == 2'd0)) ? bus.D[3:0]
                                       : {ctrl_q[3:1], ctrl_q[0] & ~en_clr_s};
    flag_d = expire_s ? 1'b1
           : ((wr_s && (off_s == 2'd1) && bus.D[0]) ? 1'b0 : flag_q);
    stg_d  = (wr_s && (off_s == 2'd2)) ? bus.D : stg_q;

    hold_d = hold_q;
    hv_d   = hv_q;
    if (rd_s && (off_s == 2'd2)) begin
      hold_d = count_q[7:0];
      hv_d   = 1'b1;
    end else if (rd_s && (off_s == 2'd3)) begin
      hv_d   = 1'b0;
    end else begin
      hv_d   = hv_q;
    end

    nirq_d  = ~(flag_q & ctrl_q[2] & ~ctrl_q[3]);
    nfirq_d = ~(flag_q & ctrl_q[2] & ctrl_q[3]);
  end

  // Read data is combinational so it is valid well before E falls.
  always_comb begin
    case (off_s)
      2'd0:    rdata_s = {4'h0, ctrl_q};
      2'd1:    rdata_s = {7'h00, flag_q};
      2'd2:    rdata_s = count_q[15:8];
      2'd3:    rdata_s = hv_q ? hold_q : count_q[7:0];
      default: rdata_s = 8'h00;
    endcase
    bus.DOE  = sel_s && bus.RnW;
    bus.DOut = (sel_s && bus.RnW) ? rdata_s : 8'h00;
  end

  // State registers.
  always_ff @(posedge CLK_ROOT or negedge nRESET) begin
    if (!nRESET) begin
      ctrl_q   <= 4'h0;
      flag_q   <= 1'b0;
      count_q  <= 16'h0000;
      reload_q <= 16'h0000;
      stg_q    <= 8'h00;
      hold_q   <= 8'h00;
      hv_q     <= 1'b0;
      nirq_q   <= 1'b1;
      nfirq_q  <= 1'b1;
    end else begin
      ctrl_q   <= ctrl_d;
      flag_q   <= flag_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      stg_q    <= stg_d;
      hold_q   <= hold_d;
      hv_q     <= hv_d;
      nirq_q   <= nirq_d;
      nfirq_q  <= nfirq_d;
    end
  end

  assign bus.nIRQ  = nirq_q;
  assign bus.nFIRQ = nfirq_q;

endmodule

// File: tb/tb_mc6809_bus_timer.sv
// Directed and randomized bench for mc6809_bus_timer against a behavioural
// register-level model of the timer.
module tb_mc6809_bus_timer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc6809_bus_timer_if bus ();

  mc6809_bus_timer #(.BASE_ADDR(16'hFF40)) dut (
    .CLK_ROOT (clk),
    .nRESET   (rst_n),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_count, m_reload;
  logic [3:0]  m_ctrl;
  logic        m_flag;
  logic [7:0]  m_stg, m_hold;
  logic        m_hv;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 16'h0000; m_reload = 16'h0000; m_ctrl = 4'h0; m_flag = 1'b0;
    m_stg = 8'h00; m_hold = 8'h00; m_hv = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] off);
    case (off)
      2'd0:    return {4'h0, m_ctrl};
      2'd1:    return {7'h00, m_flag};
      2'd2:    return m_count[15:8];
      default: return m_hv ? m_hold : m_count[7:0];
    endcase
  endfunction

  function automatic logic is_sel(input logic [15:0] a, input logic bs, input logic ba);
    return (a[15:2] == 14'h3FD0) && !ba && !bs;
  endfunction

  // One E-falling edge applied to the register-level model.
  task automatic model_edge(input logic [15:0] a, input logic [7:0] d,
                            input logic rnw, input logic bs, input logic ba);
    logic wr, rd, expired;
    logic [15:0] old_cnt;
    wr = is_sel(a, bs, ba) && !rnw;
    rd = is_sel(a, bs, ba) && rnw;
    expired = 1'b0;
    old_cnt = m_count;
    if (wr && a[1:0] == 2'd3) begin
      m_count = {m_stg, d};
      m_reload = {m_stg, d};
    end else if (m_ctrl[0]) begin
      if (m_count == 16'h0000) begin
        expired = 1'b1;
        if (m_ctrl[1]) m_count = m_reload;
        else m_ctrl[0] = 1'b0;
      end else begin
        m_count = m_count - 16'd1;
      end
    end
    if (wr && a[1:0] == 2'd1 && d[0]) m_flag = 1'b0;
    if (expired) m_flag = 1'b1;
    if (wr && a[1:0] == 2'd0) m_ctrl = d[3:0];
    if (wr && a[1:0] == 2'd2) m_stg = d;
    if (rd && a[1:0] == 2'd2) begin m_hold = old_cnt[7:0]; m_hv = 1'b1; end
    if (rd && a[1:0] == 2'd3) m_hv = 1'b0;
  endtask

  function automatic logic exp_nirq();
    return !(m_flag && m_ctrl[2] && !m_ctrl[3]);
  endfunction

  function automatic logic exp_nfirq();
    return !(m_flag && m_ctrl[2] && m_ctrl[3]);
  endfunction

  // One CPU bus cycle: CE_E_FALL for one clock, then one idle clock.
  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic rnw,
                     input logic bs, input logic ba, output logic [7:0] rd);
    logic sel, e_doe, old_irq, old_firq;
    logic [7:0] e_dout;
    @(negedge clk);
    bus.ADDR = a; bus.D = d; bus.RnW = rnw; bus.BS = bs; bus.BA = ba;
    bus.CE_E_FALL = 1'b1;
    #2;
    sel = is_sel(a, bs, ba);
    e_doe = sel && rnw;
    e_dout = e_doe ? model_read(a[1:0]) : 8'h00;
    chk("DOE", {15'h0000, bus.DOE}, {15'h0000, e_doe});
    chk("DOut", {8'h00, bus.DOut}, {8'h00, e_dout});
    rd = bus.DOut;
    old_irq = exp_nirq();
    old_firq = exp_nfirq();
    @(posedge clk);
    model_edge(a, d, rnw, bs, ba);
    #1;
    bus.CE_E_FALL = 1'b0; bus.ADDR = 16'h0000; bus.RnW = 1'b1; bus.BS = 1'b0; bus.BA = 1'b0;
    chk("nIRQ_latency", {15'h0000, bus.nIRQ}, {15'h0000, old_irq});
    chk("nFIRQ_latency", {15'h0000, bus.nFIRQ}, {15'h0000, old_firq});
    @(posedge clk);
    #1;
    chk("nIRQ", {15'h0000, bus.nIRQ}, {15'h0000, exp_nirq()});
    chk("nFIRQ", {15'h0000, bus.nFIRQ}, {15'h0000, exp_nfirq()});
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] r;
    cyc(a, d, 1'b0, 1'b0, 1'b0, r);
  endtask

  task automatic rdchk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] r;
    cyc(a, 8'h00, 1'b1, 1'b0, 1'b0, r);
    chk(tag, {8'h00, r}, {8'h00, exp});
  endtask

  task automatic idle(input int n);
    logic [7:0] r;
    for (int i = 0; i < n; i++) cyc(16'h1234, 8'h00, 1'b1, 1'b0, 1'b0, r);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [15:0] a;
    logic [7:0] d;
    logic rnw, bs, ba;
    int pick;

    bus.CE_E_FALL = 1'b0; bus.ADDR = 16'h0000; bus.D = 8'h00;
    bus.RnW = 1'b1; bus.BS = 1'b0; bus.BA = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("rst_nIRQ", {15'h0000, bus.nIRQ}, 16'h0001);
    chk("rst_nFIRQ", {15'h0000, bus.nFIRQ}, 16'h0001);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    rdchk("rst_ctrl", 16'hFF40, 8'h00);
    rdchk("rst_status", 16'hFF41, 8'h00);
    rdchk("rst_cnt_hi", 16'hFF42, 8'h00);
    rdchk("rst_cnt_lo", 16'hFF43, 8'h00);

    // Counter load and read-back
    wr(16'hFF42, 8'h12);
    wr(16'hFF43, 8'h34);
    rdchk("load_hi", 16'hFF42, 8'h12);
    rdchk("load_lo", 16'hFF43, 8'h34);

    // Auto-reload period RELOAD+1 with IRQ
    wr(16'hFF42, 8'h00);
    wr(16'hFF43, 8'h03);
    wr(16'hFF40, 8'h07);
    idle(3);
    chk("period_no_irq_yet", {15'h0000, bus.nIRQ}, 16'h0001);
    idle(1);
    chk("period_irq_low", {15'h0000, bus.nIRQ}, 16'h0000);
    wr(16'hFF41, 8'h01);
    chk("irq_cleared", {15'h0000, bus.nIRQ}, 16'h0001);
    idle(3);
    chk("period_irq_again", {15'h0000, bus.nIRQ}, 16'h0000);
    wr(16'hFF40, 8'h00);
    wr(16'hFF41, 8'h01);

    // One-shot with FIRQ
    wr(16'hFF42, 8'h00);
    wr(16'hFF43, 8'h02);
    wr(16'hFF40, 8'h0D);
    idle(3);
    chk("oneshot_nFIRQ", {15'h0000, bus.nFIRQ}, 16'h0000);
    chk("oneshot_nIRQ", {15'h0000, bus.nIRQ}, 16'h0001);
    rdchk("oneshot_ctrl", 16'hFF40, 8'h0C);
    rdchk("oneshot_status", 16'hFF41, 8'h01);
    idle(2);
    rdchk("oneshot_cnt_hi", 16'hFF42, 8'h00);
    rdchk("oneshot_cnt_lo", 16'hFF43, 8'h00);
    wr(16'hFF41, 8'h01);
    wr(16'hFF40, 8'h00);

    // Latched COUNT_LO across a borrow
    wr(16'hFF42, 8'h01);
    wr(16'hFF43, 8'h00);
    wr(16'hFF40, 8'h01);
    rdchk("latch_hi", 16'hFF42, 8'h01);
    idle(1);
    rdchk("latch_lo_held", 16'hFF43, 8'h00);
    rdchk("latch_lo_live", 16'hFF43, 8'hFD);
    wr(16'hFF40, 8'h00);

    // Same-edge collisions
    wr(16'hFF42, 8'h00);
    wr(16'hFF43, 8'h00);
    wr(16'hFF40, 8'h03);
    idle(1);
    wr(16'hFF41, 8'h01);
    rdchk("set_wins", 16'hFF41, 8'h01);
    wr(16'hFF43, 8'h55);
    rdchk("wr_wins_hi", 16'hFF42, 8'h00);
    rdchk("wr_wins_lo", 16'hFF43, 8'h55);
    wr(16'hFF40, 8'h00);
    wr(16'hFF41, 8'h01);

    // Non-selecting bus states
    cyc(16'hFF40, 8'h0F, 1'b0, 1'b0, 1'b1, r);
    cyc(16'hFF40, 8'h0F, 1'b0, 1'b1, 1'b0, r);
    cyc(16'hFF40, 8'h00, 1'b1, 1'b0, 1'b1, r);
    chk("ba_read_dout", {8'h00, r}, 16'h0000);
    cyc(16'hFF40, 8'h00, 1'b1, 1'b1, 1'b0, r);
    chk("iack_read_dout", {8'h00, r}, 16'h0000);
    rdchk("nosel_ctrl", 16'hFF40, 8'h00);

    // Reset pulse mid-count
    wr(16'hFF42, 8'h00);
    wr(16'hFF43, 8'h01);
    wr(16'hFF40, 8'h07);
    idle(3);
    chk("pre_rst_irq", {15'h0000, bus.nIRQ}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("async_rst_nIRQ", {15'h0000, bus.nIRQ}, 16'h0001);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    rdchk("post_rst_ctrl", 16'hFF40, 8'h00);
    rdchk("post_rst_status", 16'hFF41, 8'h00);
    rdchk("post_rst_hi", 16'hFF42, 8'h00);
    rdchk("post_rst_lo", 16'hFF43, 8'h00);

    // Randomized bus traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) a = {14'h3FD0, 2'($urandom_range(0, 3))};
      else a = 16'($urandom);
      rnw = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (a[1:0] == 2'd2 && !rnw) d = 8'($urandom_range(0, 1));
      pick = $urandom_range(0, 7);
      ba = (pick == 0);
      bs = (pick == 1);
      cyc(a, d, rnw, bs, ba, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc6809_bus_timer.md
MC6809_BUS_TIMER -- requirements
Module: mc6809_bus_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFF40, giving the base of its 4-byte register window; bits [1:0] are ignored.
REQ-002 CLK_ROOT  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-003 nRESET  input  1  reset, asynchronous and active-low.
REQ-004 CE_E_FALL  input  1  one-CLK_ROOT-wide enable marking the E falling edge, which is the end of a CPU bus cycle.
REQ-005 ADDR  input  16  CPU address.
REQ-006 D  input  8  CPU write data.
REQ-007 RnW  input  1  1 = CPU read, 0 = CPU write.
REQ-008 BS  input  1  CPU bus status.
REQ-009 BA  input  1  CPU bus available.
REQ-010 DOut  output  8  read data returned to the CPU.
REQ-011 DOE  output  1  read-data drive enable toward the CPU data bus.
REQ-012 nIRQ  output  1  active-low IRQ request to the CPU.
REQ-013 nFIRQ  output  1  active-low FIRQ request to the CPU.

Function
REQ-014 The block SHALL be selected when ADDR[15:2]==BASE_ADDR[15:2], BA==0 and BS==0; BA=1 (bus granted/halted) and BS=1,BA=0 (interrupt acknowledge) SHALL never select it.
REQ-015 Register map SHALL be: offset 0 CTRL (R/W), 1 STATUS, 2 COUNT_HI/RELOAD_HI, 3 COUNT_LO/RELOAD_LO.
REQ-016 CTRL bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable), bit3 FSEL (1 = FIRQ, 0 = IRQ); bits[7:4] SHALL read 0.
REQ-017 STATUS bit0 FLAG (expired), other bits read 0; writing 1 to bit0 SHALL clear FLAG, writing 0 SHALL leave it unchanged.
REQ-018 Writes SHALL take effect only on a CLK_ROOT edge with CE_E_FALL=1, selected and RnW=0.
REQ-019 Write to offset 2 SHALL store D in an 8-bit staging register only.
REQ-020 Write to offset 3 SHALL load RELOAD={staging,D} and COUNT={staging,D} in the same edge.
REQ-021 DOut SHALL be combinational from ADDR[1:0] and register state, so it is valid before E falls; DOE = selected & RnW.
REQ-022 Read of offset 2 SHALL return COUNT[15:8]; on its CE_E_FALL edge, HOLD<=COUNT[7:0] and HV<=1.
REQ-023 Read of offset 3 SHALL return HOLD if HV=1, else COUNT[7:0]; on its CE_E_FALL edge HV<=0.
REQ-024 When DOE=0, DOut SHALL be 8'h00.
REQ-025 Tick: each CE_E_FALL edge with EN=1 SHALL be a tick; if COUNT!=0 then COUNT<=COUNT-1, else an expiry event occurs.
REQ-026 Expiry SHALL set FLAG and, if AUTO=1, load COUNT<=RELOAD; if AUTO=0, clear EN and leave COUNT at 0.
REQ-027 Period with AUTO=1 SHALL be RELOAD+1 ticks; RELOAD=0 SHALL expire on every tick.
REQ-028 An expiry on the same edge as a STATUS clear-write SHALL leave FLAG=1 (set wins).
REQ-029 An offset-3 write on a tick edge SHALL win: COUNT takes the written value, no decrement and no expiry on that edge.
REQ-030 A CTRL write on a tick edge SHALL use the old EN for that tick and the new CTRL value afterward.
REQ-031 nIRQ SHALL be registered: 0 when FLAG&IE&~FSEL, else 1; nFIRQ registered: 0 when FLAG&IE&FSEL, else 1; one CLK_ROOT of latency from the state change.
REQ-032 Requests SHALL be level: they hold until FLAG is cleared or IE/FSEL change.

Reset
REQ-033 With nRESET=0, asynchronously: CTRL=0, FLAG=0, COUNT=0, RELOAD=0, staging=0, HOLD=0, HV=0, nIRQ=1, nFIRQ=1.
REQ-034 Reset mid-count SHALL abort the count; after release no tick occurs until EN is written to 1.

Verification
REQ-035 Write FF42=12h, then FF43=34h -> RELOAD=COUNT=1234h; reading FF42 then FF43 -> 12h, 34h.
REQ-036 RELOAD=0003h, CTRL=07h -> FLAG sets on the 4th tick and every 4 ticks after; nIRQ goes low one CLK_ROOT after the first set; writing STATUS=01h -> nIRQ high one CLK_ROOT later.
REQ-037 RELOAD=0002h, CTRL=0Dh (one-shot, FIRQ) -> after 3 ticks FLAG=1, nFIRQ=0, nIRQ=1, CTRL reads 0Ch, COUNT stays 0000h.
REQ-038 COUNT=0100h, EN=1 -> read FF42 returns 01h; a tick occurs before the FF43 read -> FF43 returns 00h (held), not FFh.
REQ-039 Same-edge STATUS clear and expiry -> FLAG=1; same-edge offset-3 write of 55h (staging 00h) and tick -> COUNT=0055h.
REQ-040 Access at FF40 with BA=1, or with BS=1,BA=0 -> DOE=0 and no register change; nRESET pulse mid-count -> all values as in REQ-033.
